// File: rtl/multi_counter_pkg.sv
// -----------------------------------------------------------------------------
// multi_counter_pkg
//   Definitions shared by the multi_counter_bus top level and its
//   counter_channel instances:
//     - the per-channel FSM state encoding
//     - bit offsets inside a channel's 2-bit mode field
//     - a helper that computes the first count value after a start or reload
//     - a helper that computes the terminal count for a run
// -----------------------------------------------------------------------------
package multi_counter_pkg;

    // Per-channel control state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_t;

    // Bit positions inside one channel's mode field
    localparam int MODE_DIR  = 0;   // 0: count down, 1: count up
    localparam int MODE_AUTO = 1;   // 1: reload automatically at terminal count

    // First count value of a run.
    // Down-counters start at the reload value and end at zero.
    // Up-counters start at zero and end at the reload value.
    function automatic logic [31:0] start_value(input logic up, input logic [31:0] reload);
        return up ? 32'd0 : reload;
    endfunction

    // Terminal count of a run; the counterpart of start_value.
    function automatic logic [31:0] term_value(input logic up, input logic [31:0] reload);
        return up ? reload : 32'd0;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// -----------------------------------------------------------------------------
// counter_channel
//   One loadable up/down counter with a trigger-edge start, optional
//   auto-reload and a registered one-cycle terminal-count pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   load_en    in   write load_data into the reload register on this edge
//   load_data  in   [WIDTH-1:0] reload value from the shared bus
//   trig       in   start request; a rising edge is detected synchronously
//   mode       in   [1:0] bit MODE_DIR = up, bit MODE_AUTO = auto-reload
//   count      out  [WIDTH-1:0] live count value
//   out_pulse  out  one-cycle pulse emitted when the count reaches its terminal value
//   busy       out  1 while the channel is in RUN
// -----------------------------------------------------------------------------
module counter_channel #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             trig,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             out_pulse,
    output logic             busy
);
    import multi_counter_pkg::*;

    chan_state_t      state, state_n;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] term, term_n;
    logic             up, up_n;
    logic             auto_rl, auto_rl_n;
    logic             trig_q;
    logic             trig_edge;
    logic             at_term;
    logic             pulse_n;
    logic [WIDTH-1:0] mode_start;
    logic [WIDTH-1:0] mode_term;
    logic [WIDTH-1:0] run_start;
    logic [WIDTH-1:0] run_term;

    assign trig_edge = trig & ~trig_q;
    assign at_term   = (count == term);
    assign busy      = (state == ST_RUN);

    // Start/terminal values for a fresh start use the direction on the mode
    // pins; those for an auto-reload use the direction latched at start.
    // Both read the reload register before any same-edge load lands.
    assign mode_start = WIDTH'(start_value(mode[MODE_DIR], 32'(reload)));
    assign mode_term  = WIDTH'(term_value(mode[MODE_DIR], 32'(reload)));
    assign run_start  = WIDTH'(start_value(up, 32'(reload)));
    assign run_term   = WIDTH'(term_value(up, 32'(reload)));

    // Reload register and trigger history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload <= '0;
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
            if (load_en) begin
                reload <= load_data;
            end
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        state_n   = state;
        count_n   = count;
        term_n    = term;
        up_n      = up;
        auto_rl_n = auto_rl;
        pulse_n   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (trig_edge) begin
                    state_n   = ST_RUN;
                    count_n   = mode_start;
                    term_n    = mode_term;
                    up_n      = mode[MODE_DIR];
                    auto_rl_n = mode[MODE_AUTO];
                end
            end

            ST_RUN: begin
                // A terminal count always produces its pulse, even when a
                // retrigger on the same edge restarts the run.
                pulse_n = at_term;
                if (trig_edge) begin
                    count_n   = mode_start;
                    term_n    = mode_term;
                    up_n      = mode[MODE_DIR];
                    auto_rl_n = mode[MODE_AUTO];
                end else if (at_term) begin
                    if (auto_rl) begin
                        // A reload written mid-run first takes effect here.
                        count_n = run_start;
                        term_n  = run_term;
                    end else begin
                        state_n = ST_DONE;
                    end
                end else if (up) begin
                    count_n = count + WIDTH'(1);
                end else begin
                    count_n = count - WIDTH'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            term      <= '0;
            up        <= 1'b0;
            auto_rl   <= 1'b0;
            out_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            term      <= term_n;
            up        <= up_n;
            auto_rl   <= auto_rl_n;
            out_pulse <= pulse_n;
        end
    end

endmodule

// File: rtl/multi_counter_bus.sv
// -----------------------------------------------------------------------------
// multi_counter_bus
//   Bank of CHANNELS loadable counters sharing one bidirectional data bus.
//   The host writes per-channel reload values over the bus (we=0) and reads
//   back live counts (we=1). Each channel is an independent counter_channel.
//
// Ports
//   clk        in     rising-edge clock
//   rst        in     asynchronous active-low reset
//   data       inout  [WIDTH-1:0] shared bus; host drives when we=0,
//                     this block drives count[addr] when we=1 and rst=1
//   addr       in     [ADDR_W-1:0] channel select for load and readback
//   we         in     bus direction (0: load reload[addr], 1: read count[addr])
//   trig       in     [CHANNELS-1:0] per-channel start request
//   mode       in     [2*CHANNELS-1:0] channel i uses bits 2i+1:2i
//   out_pulse  out    [CHANNELS-1:0] registered terminal-count pulses
//   busy       out    [CHANNELS-1:0] channel is in RUN
// -----------------------------------------------------------------------------
module multi_counter_bus #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [WIDTH-1:0]      data,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [CHANNELS-1:0]   trig,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   out_pulse,
    output logic [CHANNELS-1:0]   busy
);
    import multi_counter_pkg::*;

    logic [WIDTH-1:0]    count [CHANNELS];
    logic [CHANNELS-1:0] load_en;
    logic [WIDTH-1:0]    rd_data;

    // Address decode: addresses with no channel behind them neither load
    // nor read back anything but zero.
    always_comb begin
        load_en = '0;
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(addr) == i) begin
                load_en[i] = ~we;
                rd_data    = count[i];
            end
        end
    end

    // The bus is released during reset so the host never fights the block
    // while it is coming up.
    assign data = (we && rst) ? rd_data : 'z;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        counter_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load_en   (load_en[g]),
            .load_data (data),
            .trig      (trig[g]),
            .mode      (mode[2*g+1 -: 2]),
            .count     (count[g]),
            .out_pulse (out_pulse[g]),
            .busy      (busy[g])
        );
    end

endmodule

// File: tb/tb_multi_counter_bus.sv
module tb_multi_counter_bus;
    localparam int W  = 4;
    localparam int CH = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          we = 1'b1;
    logic [CH-1:0] trig = '0;
    logic [2*CH-1:0] mode = '0;
    logic [W-1:0]  host_data = '0;
    logic [CH-1:0] out_pulse;
    logic [CH-1:0] busy;

    // Pulled-up bus: an undriven bus reads all ones, so a released bus
    // is distinguishable from the block driving a zero count.
    tri1 [W-1:0] data;
    assign data = we ? 'z : host_data;

    int checks = 0;
    int errors = 0;

    multi_counter_bus #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .addr      (addr),
        .we        (we),
        .trig      (trig),
        .mode      (mode),
        .out_pulse (out_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        trig = '0;
        mode = '0;
        we   = 1'b1;
        addr = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic load(input int ch, input logic [W-1:0] val);
        we        = 1'b0;
        addr      = AW'(ch);
        host_data = val;
        tick();
        we = 1'b1;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  din;
        logic [CH-1:0] trig;
        logic [7:0]    mode;
        logic          chk_rd;
        logic [W-1:0]  exp_rd;
        logic [CH-1:0] exp_busy;
        logic [CH-1:0] exp_pulse;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [CH-1:0] seen;
        logic [CH-1:0] exp_p;

        // ch1 one-shot down from 5, then ch2 auto-reload up to 3
        vecs[0]  = '{1'b0, 2'd1, 4'd5, 4'b0000, 8'h00, 1'b0, 4'd0, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd5, 4'b0010, 4'b0000};
        vecs[2]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd4, 4'b0010, 4'b0000};
        vecs[3]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd3, 4'b0010, 4'b0000};
        vecs[4]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd2, 4'b0010, 4'b0000};
        vecs[5]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd1, 4'b0010, 4'b0000};
        vecs[6]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd0, 4'b0010, 4'b0000};
        vecs[7]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd0, 4'b0000, 4'b0010};
        vecs[8]  = '{1'b1, 2'd1, 4'd0, 4'b0010, 8'h00, 1'b1, 4'd0, 4'b0000, 4'b0000};
        vecs[9]  = '{1'b0, 2'd2, 4'd3, 4'b0010, 8'h30, 1'b0, 4'd0, 4'b0000, 4'b0000};
        vecs[10] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd0, 4'b0100, 4'b0000};
        vecs[11] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd1, 4'b0100, 4'b0000};
        vecs[12] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd2, 4'b0100, 4'b0000};
        vecs[13] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd3, 4'b0100, 4'b0000};
        vecs[14] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd0, 4'b0100, 4'b0100};
        vecs[15] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd1, 4'b0100, 4'b0000};
        vecs[16] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd2, 4'b0100, 4'b0000};
        vecs[17] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd3, 4'b0100, 4'b0000};
        vecs[18] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd0, 4'b0100, 4'b0100};
        vecs[19] = '{1'b1, 2'd2, 4'd0, 4'b0110, 8'h30, 1'b1, 4'd1, 4'b0100, 4'b0000};

        // Reset and bus release
        rst = 1'b0;
        we  = 1'b1;
        tick();
        tick();
        check("rst_bus_z", 8'(data), 8'hF);
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_pulse", 8'(out_pulse), 8'h0);
        rst = 1'b1;
        #1;
        check("post_rst_rd", 8'(data), 8'h0);
        check("post_rst_pulse", 8'(out_pulse), 8'h0);

        // Table-driven one-shot down and auto-reload up
        for (int r = 0; r < 20; r++) begin
            we        = vecs[r].we;
            addr      = vecs[r].addr;
            host_data = vecs[r].din;
            trig      = vecs[r].trig;
            mode      = vecs[r].mode;
            tick();
            if (vecs[r].chk_rd) check($sformatf("vec%0d_rd", r), 8'(data), 8'(vecs[r].exp_rd));
            check($sformatf("vec%0d_busy", r), 8'(busy), 8'(vecs[r].exp_busy));
            check($sformatf("vec%0d_pulse", r), 8'(out_pulse), 8'(vecs[r].exp_pulse));
        end

        // Reload changed mid-run: current period 5 cycles, then 3-cycle periods
        do_reset();
        load(0, 4'd4);
        mode = 8'h02;
        addr = 2'd0;
        trig = 4'b0001;
        tick();
        check("ldrun_start", 8'(data), 8'd4);
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                we = 1'b0; addr = 2'd0; host_data = 4'd2;
            end else begin
                we = 1'b1;
            end
            tick();
            check($sformatf("ldrun_pulse_k%0d", k), 8'(out_pulse[0]),
                  8'((k == 5 || k == 8 || k == 11) ? 1 : 0));
        end

        // reload=0 one-shot: pulse on the second edge, then DONE
        do_reset();
        addr = 2'd3;
        trig = 4'b1000;
        tick();
        check("z1_busy", 8'(busy), 8'b1000);
        check("z1_pulse", 8'(out_pulse), 8'h0);
        tick();
        check("z1_pulse_hi", 8'(out_pulse), 8'b1000);
        check("z1_done_busy", 8'(busy), 8'h0);
        tick();
        check("z1_pulse_lo", 8'(out_pulse), 8'h0);
        check("z1_rd", 8'(data), 8'h0);

        // reload=0 auto-reload: a pulse every cycle while running
        do_reset();
        mode = 8'h20;
        trig = 4'b0100;
        tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("z0auto_pulse_k%0d", k), 8'(out_pulse), 8'b0100);
            check($sformatf("z0auto_busy_k%0d", k), 8'(busy), 8'b0100);
        end

        // Retrigger exactly at terminal count
        do_reset();
        load(1, 4'd2);
        addr = 2'd1;
        trig = 4'b0010;
        tick();
        check("rt_start", 8'(data), 8'd2);
        trig = 4'b0000;
        tick();
        tick();
        check("rt_at_term", 8'(data), 8'd0);
        trig = 4'b0010;
        tick();
        check("rt_pulse", 8'(out_pulse), 8'b0010);
        check("rt_busy", 8'(busy), 8'b0010);
        check("rt_restart", 8'(data), 8'd2);
        tick();
        check("rt_pulse_lo", 8'(out_pulse), 8'h0);
        check("rt_cnt1", 8'(data), 8'd1);
        tick();
        tick();
        check("rt_pulse2", 8'(out_pulse), 8'b0010);
        check("rt_done", 8'(busy), 8'h0);

        // Reset mid-count: no pulse, busy drops immediately
        do_reset();
        load(0, 4'd5);
        addr = 2'd0;
        trig = 4'b0001;
        tick();
        tick();
        tick();
        check("mr_busy_pre", 8'(busy), 8'b0001);
        check("mr_cnt_pre", 8'(data), 8'd3);
        rst  = 1'b0;
        trig = 4'b0000;
        #1;
        check("mr_busy", 8'(busy), 8'h0);
        check("mr_bus_z", 8'(data), 8'hF);
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen |= out_pulse;
        end
        rst = 1'b1;
        #1;
        check("mr_rd", 8'(data), 8'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            seen |= out_pulse | busy;
        end
        check("mr_no_pulse", 8'(seen), 8'h0);

        // All channels with different reloads; addr=3 load mid-run
        do_reset();
        load(0, 4'd1);
        load(1, 4'd2);
        load(2, 4'd3);
        load(3, 4'd4);
        trig = 4'b1111;
        tick();
        check("iso_busy", 8'(busy), 8'hF);
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) begin
                we = 1'b0; addr = 2'd3; host_data = 4'd9;
            end else begin
                we = 1'b1;
            end
            tick();
            exp_p = '0;
            if (k == 2) exp_p[0] = 1'b1;
            if (k == 3) exp_p[1] = 1'b1;
            if (k == 4) exp_p[2] = 1'b1;
            if (k == 5) exp_p[3] = 1'b1;
            check($sformatf("iso_pulse_k%0d", k), 8'(out_pulse), 8'(exp_p));
        end
        for (int c = 0; c < CH; c++) begin
            addr = AW'(c);
            #1;
            check($sformatf("iso_rd_ch%0d", c), 8'(data), 8'h0);
        end
        trig = 4'b0000;
        tick();
        trig = 4'b1000;
        addr = 2'd3;
        tick();
        check("iso_ch3_new_reload", 8'(data), 8'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
